multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARMv4 datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives ALUOp into ALU_DECODER and receives that decoder's FlagW. Holds the NZCV flag register, evaluates the condition field once per instruction, and gates every architectural write enable with the result.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- Cond  in  4  instruction bits [31:28].
- Op  in  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- Funct  in  6  instruction bits [25:20]: [5] immediate, [0] S (data-processing) or L (memory).
- Rd  in  4  instruction bits [15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle.
- FlagW  in  2  from ALU_DECODER: [1] updates NZ, [0] updates CV.
- ALUOp  out  1  to ALU_DECODER; 1 selects the data-processing decode.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables.
- AdrSrc  out  1  0 = PC, 1 = ALU result register.
- ALUSrcA  out  2  00 = register A, 01 = PC.
- ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- ImmSrc  out  2  equals Op.
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR if Op=01; →EXECUTEI if Op=00 and Funct[5]; →EXECUTER if Op=00 and !Funct[5]; →BRANCH if Op=10; →FETCH if Op=11 (NOP).
  - MEMADR→MEMRD if Funct[0], else →MEMWR.
  - MEMRD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
- Moore outputs per state. Every field not listed is 0.
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUOp=1, ALUSrcB=01.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Condition check:
  - CondEx is evaluated in DECODE against the flag register and captured into CondExReg. It holds until the next DECODE.
  - Codes: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
- Gating:
  - RegWrite = RegW & CondExReg.
  - MemWrite = MemW & CondExReg.
  - PCS = Branch | (RegW & Rd==15).
  - PCWrite = NextPC | (PCS & CondExReg).
- Flags:
  - FlagWrite = ALUOp & CondExReg.
  - NZ ← ALUFlags[3:2] when FlagWrite & FlagW[1].
  - CV ← ALUFlags[1:0] when FlagWrite & FlagW[0].

## Timing
- Latency in cycles: B 3, data-processing 4, STR 4, LDR 5, Op=11 2.
- Outputs are combinational from the registered state, CondExReg and Rd. There is no output register.
- Flags update on the clock edge that ends EXECUTER/EXECUTEI. A following instruction sees them at its own DECODE.
- While rst_n=0, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0.
- Reset values after the edge: state FETCH, NZCV=0000, CondExReg=0.
- Reset in any state, including mid-instruction (e.g. MEMWR), aborts the instruction. No write enable fires on the reset cycle. The first cycle after release is FETCH.
- Rd, Op, Funct and Cond are stable from DECODE onward, because the instruction register updates only in FETCH.

## Structure
- Shared package holds:
  - state enum (4-bit encoding);
  - select encodings for ALUSrcA, ALUSrcB, ResultSrc and AdrSrc;
  - Op encodings;
  - condition-code constants.
- One sub-module, cond_logic, contains:
  - the NZCV register;
  - the condition evaluator;
  - CondExReg;
  - the write-enable gating.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset: rst_n=0 for 2 cycles with Op=00 → all write enables 0. After release: IRWrite=1, PCWrite=1, ALUSrcB=10, then DECODE.
- ADD register (Cond=1110, Op=00, Funct=001000, Rd=1) → EXECUTER→ALUWB. RegWrite=1 only in ALUWB, PCWrite=0 there. 4 cycles total.
- SUBS immediate (Funct=100101, ALUFlags=0100 in EXECUTEI) → Z=1. Then BEQ (Op=10, Cond=0000) → PCWrite=1 in BRANCH. Then BNE (Cond=0001) → PCWrite=0 in BRANCH.
- LDR (Op=01, Funct=011001) → MEMRD with AdrSrc=1, then MEMWB with ResultSrc=01 and RegWrite=1. STR (Funct=011000) → MEMWR with MemWrite=1, 4 cycles.
- ADD with Rd=15 → ALUWB asserts RegWrite=1 and PCWrite=1. Same instruction with Cond=0000 and Z=0 → both 0 in ALUWB, flags unchanged.
- rst_n=0 during MEMWR → MemWrite=0 that cycle, next state FETCH, NZCV=0000.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle ARMv4 control unit.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_UND     = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c & !z;
      COND_LS: return !c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields, ALU flags and datapath controls between the control unit and the datapath.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       ALUOp;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, FlagW,
    input  ALUOp, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, FlagW,
    output ALUOp, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc
  );
endinterface

// File: rtl/multicycle_controller_cond_logic.sv
// Condition logic: NZCV register, per-instruction condition result and write-enable gating.
module multicycle_controller_cond_logic
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic [1:0] i_flag_w,
  input  logic [3:0] i_rd,
  input  logic       i_cond_sample,
  input  logic       i_alu_op,
  input  logic       i_reg_w,
  input  logic       i_mem_w,
  input  logic       i_next_pc,
  input  logic       i_branch,
  output logic       o_pc_write,
  output logic       o_reg_write,
  output logic       o_mem_write
);

  logic [1:0] r_nz;
  logic [1:0] r_cv;
  logic       r_cond_ex;
  logic       w_flag_write;
  logic       w_pcs;

  assign w_flag_write = i_alu_op & r_cond_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nz      <= 2'b00;
      r_cv      <= 2'b00;
      r_cond_ex <= 1'b0;
    end else begin
      if (i_cond_sample)
        r_cond_ex <= cond_eval(i_cond, {r_nz, r_cv});
      if (w_flag_write && i_flag_w[1])
        r_nz <= i_alu_flags[3:2];
      if (w_flag_write && i_flag_w[0])
        r_cv <= i_alu_flags[1:0];
    end
  end

  // Writing R15 from ALUWB/MEMWB is a jump, so it also needs PCWrite.
  assign w_pcs       = i_branch | (i_reg_w & (i_rd == 4'd15));
  assign o_reg_write = rst_n & i_reg_w & r_cond_ex;
  assign o_mem_write = rst_n & i_mem_w & r_cond_ex;
  assign o_pc_write  = rst_n & (i_next_pc | (w_pcs & r_cond_ex));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARMv4 control unit: state sequencing and Moore output decode.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_controller_if.slave bus
);

  state_e     r_state;
  state_e     w_next_state;
  logic       w_ir_write, w_next_pc, w_reg_w, w_mem_w, w_branch, w_alu_op, w_adr_src;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_result_src;
  logic       w_pc_write, w_reg_write, w_mem_write;
  logic       w_unused;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM:  w_next_state = S_MEMADR;
          OP_DP:   w_next_state = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   w_next_state = S_BRANCH;
          default: w_next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   w_next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next_state = S_MEMWB;
      S_EXECUTER: w_next_state = S_ALUWB;
      S_EXECUTEI: w_next_state = S_ALUWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    w_alu_op     = 1'b0;
    w_adr_src    = ADR_PC;
    w_alu_src_a  = SRCA_REG;
    w_alu_src_b  = SRCB_REG;
    w_result_src = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_ir_write   = 1'b1;
        w_next_pc    = 1'b1;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
      end
      S_DECODE: begin
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALU;
      end
      S_MEMADR: w_alu_src_b = SRCB_IMM;
      S_MEMRD:  w_adr_src   = ADR_ALUOUT;
      S_MEMWB: begin
        w_result_src = RES_RDATA;
        w_reg_w      = 1'b1;
      end
      S_MEMWR: begin
        w_adr_src = ADR_ALUOUT;
        w_mem_w   = 1'b1;
      end
      S_EXECUTER: w_alu_op = 1'b1;
      S_EXECUTEI: begin
        w_alu_op    = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      S_ALUWB: w_reg_w = 1'b1;
      S_BRANCH: begin
        w_alu_src_b  = SRCB_IMM;
        w_result_src = RES_ALU;
        w_branch     = 1'b1;
      end
      default: ;
    endcase
  end

  multicycle_controller_cond_logic u_cond_logic (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cond        (bus.Cond),
    .i_alu_flags   (bus.ALUFlags),
    .i_flag_w      (bus.FlagW),
    .i_rd          (bus.Rd),
    .i_cond_sample (r_state == S_DECODE),
    .i_alu_op      (w_alu_op),
    .i_reg_w       (w_reg_w),
    .i_mem_w       (w_mem_w),
    .i_next_pc     (w_next_pc),
    .i_branch      (w_branch),
    .o_pc_write    (w_pc_write),
    .o_reg_write   (w_reg_write),
    .o_mem_write   (w_mem_write)
  );

  assign bus.ALUOp     = w_alu_op;
  assign bus.IRWrite   = w_ir_write & rst_n;
  assign bus.PCWrite   = w_pc_write;
  assign bus.RegWrite  = w_reg_write;
  assign bus.MemWrite  = w_mem_write;
  assign bus.AdrSrc    = w_adr_src;
  assign bus.ALUSrcA   = w_alu_src_a;
  assign bus.ALUSrcB   = w_alu_src_b;
  assign bus.ResultSrc = w_result_src;
  assign bus.ImmSrc    = bus.Op;
  assign bus.RegSrc    = {bus.Op == OP_MEM, bus.Op == OP_BR};

  // Funct[4:1] selects the ALU operation and is consumed by ALU_DECODER, not here.
  assign w_unused = ^bus.Funct[4:1];

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller against an instruction-level reference model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4;
  localparam int P_MEMWR = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9;

  logic [3:0]  m_nzcv = 4'b0000;
  logic        m_ce = 1'b0;
  int          ph_q [8];
  logic [15:0] exp_q [8];
  logic [15:0] obs_q [8];
  int          n_ph;

  wire [15:0] w_obs = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.ImmSrc, bus.RegSrc};
  wire [3:0]  w_wen = {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite};

  function automatic string ph_name(input int ph);
    case (ph)
      P_FETCH:  return "FETCH";
      P_DECODE: return "DECODE";
      P_MEMADR: return "MEMADR";
      P_MEMRD:  return "MEMRD";
      P_MEMWB:  return "MEMWB";
      P_MEMWR:  return "MEMWR";
      P_EXECR:  return "EXECUTER";
      P_EXECI:  return "EXECUTEI";
      P_ALUWB:  return "ALUWB";
      default:  return "BRANCH";
    endcase
  endfunction

  // Odd condition codes are the complement of the even code just below them.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy & !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [15:0] model_out(input int ph, input logic ce, input logic [1:0] op,
                                            input logic [3:0] rd);
    logic irw, npc, regw, memw, br, aluop, adr, pcw;
    logic [1:0] sa, sb, rs;
    irw = 0; npc = 0; regw = 0; memw = 0; br = 0; aluop = 0; adr = 0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (ph)
      P_FETCH:  begin irw = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      P_DECODE: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      P_MEMADR: sb = 2'b01;
      P_MEMRD:  adr = 1;
      P_MEMWB:  begin rs = 2'b01; regw = 1; end
      P_MEMWR:  begin adr = 1; memw = 1; end
      P_EXECR:  aluop = 1;
      P_EXECI:  begin aluop = 1; sb = 2'b01; end
      P_ALUWB:  regw = 1;
      default:  begin sb = 2'b01; rs = 2'b10; br = 1; end
    endcase
    pcw = npc | (ce & (br | (regw & (rd == 4'd15))));
    return {pcw, memw & ce, regw & ce, irw, adr, sa, sb, rs, aluop, op,
            (op == 2'b01), (op == 2'b10)};
  endfunction

  // Runs one instruction from its FETCH, recording expected/observed outputs per cycle.
  // stop_at >= 0 leaves the DUT just after entering that phase without sampling it.
  task automatic run_instr(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                           input logic [3:0] rd, input logic [3:0] flags, input logic [1:0] flagw,
                           input int stop_at);
    int phs[$];
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
    bus.ALUFlags = flags; bus.FlagW = flagw;
    phs = {P_FETCH, P_DECODE};
    case (op)
      2'b00: begin phs.push_back(funct[5] ? P_EXECI : P_EXECR); phs.push_back(P_ALUWB); end
      2'b01: begin
        phs.push_back(P_MEMADR);
        if (funct[0]) begin phs.push_back(P_MEMRD); phs.push_back(P_MEMWB); end
        else phs.push_back(P_MEMWR);
      end
      2'b10: phs.push_back(P_BRANCH);
      default: ;
    endcase
    n_ph = 0;
    for (int p = 0; p < phs.size(); p++) begin
      if (p == stop_at) break;
      ph_q[p]  = phs[p];
      exp_q[p] = model_out(phs[p], m_ce, op, rd);
      @(negedge clk);
      obs_q[p] = w_obs;
      @(posedge clk);
      #1;
      n_ph++;
      if (phs[p] == P_DECODE) m_ce = model_cond(cond, m_nzcv);
      if ((phs[p] == P_EXECR || phs[p] == P_EXECI) && m_ce) begin
        if (flagw[1]) m_nzcv[3:2] = flags[3:2];
        if (flagw[0]) m_nzcv[1:0] = flags[1:0];
      end
    end
  endtask

  task automatic test_reset();
    bus.Cond = 4'b1110; bus.Op = 2'b00; bus.Funct = 6'b0; bus.Rd = 4'd0;
    bus.ALUFlags = 4'b0; bus.FlagW = 2'b0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests_run++;
      if (w_wen !== 4'b0000) begin
        tests_failed++;
        $display("FAIL reset_wen got %b expected 0000", w_wen);
      end
      @(posedge clk);
    end
    #1 rst_n = 1'b1;
    m_nzcv = 4'b0000; m_ce = 1'b0;
    run_instr(4'b1110, 2'b11, 6'b0, 4'd0, 4'b0, 2'b0, -1);
    for (int p = 0; p < n_ph; p++) begin
      tests_run++;
      if (obs_q[p] !== exp_q[p]) begin
        tests_failed++;
        $display("FAIL reset_release %s got %h expected %h", ph_name(ph_q[p]), obs_q[p], exp_q[p]);
      end
    end
  endtask

  task automatic test_add_reg();
    run_instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b1010, 2'b00, -1);
    for (int p = 0; p < n_ph; p++) begin
      tests_run++;
      if (obs_q[p] !== exp_q[p]) begin
        tests_failed++;
        $display("FAIL add_reg %s got %h expected %h", ph_name(ph_q[p]), obs_q[p], exp_q[p]);
      end
    end
  endtask

  task automatic test_subs_branch();
    logic [3:0] conds [3];
    logic [1:0] ops [3];
    logic [5:0] fns [3];
    conds = '{4'b1110, 4'b0000, 4'b0001};
    ops   = '{2'b00, 2'b10, 2'b10};
    fns   = '{6'b100101, 6'b000000, 6'b000000};
    for (int i = 0; i < 3; i++) begin
      run_instr(conds[i], ops[i], fns[i], 4'd2, 4'b0100, 2'b11, -1);
      for (int p = 0; p < n_ph; p++) begin
        tests_run++;
        if (obs_q[p] !== exp_q[p]) begin
          tests_failed++;
          $display("FAIL subs_branch[%0d] %s got %h expected %h", i, ph_name(ph_q[p]),
                   obs_q[p], exp_q[p]);
        end
      end
    end
  endtask

  task automatic test_ldr_str();
    logic [5:0] fns [2];
    fns = '{6'b011001, 6'b011000};
    for (int i = 0; i < 2; i++) begin
      run_instr(4'b1110, 2'b01, fns[i], 4'd3, 4'b0, 2'b0, -1);
      for (int p = 0; p < n_ph; p++) begin
        tests_run++;
        if (obs_q[p] !== exp_q[p]) begin
          tests_failed++;
          $display("FAIL ldr_str[%0d] %s got %h expected %h", i, ph_name(ph_q[p]),
                   obs_q[p], exp_q[p]);
        end
      end
    end
  endtask

  // ADDS clears Z, ADD pc under AL jumps, ADD pc under EQ is squashed and must not touch
  // flags, and the BEQ/BCS afterwards expose whether the flags survived.
  task automatic test_pc_dest();
    logic [3:0] conds [5];
    logic [1:0] ops [5];
    logic [5:0] fns [5];
    logic [3:0] rds [5];
    logic [3:0] fls [5];
    conds = '{4'b1110, 4'b1110, 4'b0000, 4'b0000, 4'b0010};
    ops   = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10};
    fns   = '{6'b001001, 6'b001000, 6'b001001, 6'b0, 6'b0};
    rds   = '{4'd4, 4'd15, 4'd15, 4'd0, 4'd0};
    fls   = '{4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1111};
    for (int i = 0; i < 5; i++) begin
      run_instr(conds[i], ops[i], fns[i], rds[i], fls[i], 2'b11, -1);
      for (int p = 0; p < n_ph; p++) begin
        tests_run++;
        if (obs_q[p] !== exp_q[p]) begin
          tests_failed++;
          $display("FAIL pc_dest[%0d] %s got %h expected %h", i, ph_name(ph_q[p]),
                   obs_q[p], exp_q[p]);
        end
      end
    end
  endtask

  task automatic test_reset_midinstr();
    logic [3:0] conds [4];
    run_instr(4'b1110, 2'b00, 6'b100001, 4'd5, 4'b1111, 2'b11, -1);
    run_instr(4'b1110, 2'b01, 6'b011000, 4'd6, 4'b0, 2'b0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (w_wen !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_in_memwr wen got %b expected 0000", w_wen);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_nzcv = 4'b0000; m_ce = 1'b0;
    conds = '{4'b0000, 4'b0010, 4'b0100, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      run_instr(conds[i], 2'b10, 6'b0, 4'd0, 4'b0, 2'b0, -1);
      for (int p = 0; p < n_ph; p++) begin
        tests_run++;
        if (obs_q[p] !== exp_q[p]) begin
          tests_failed++;
          $display("FAIL after_reset[%0d] %s got %h expected %h", i, ph_name(ph_q[p]),
                   obs_q[p], exp_q[p]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] c, rd, fl;
    logic [1:0] op, fw;
    logic [5:0] fn;
    for (int i = 0; i < 60; i++) begin
      c  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom_range(0, 63));
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      fl = 4'($urandom_range(0, 15));
      fw = 2'($urandom_range(0, 3));
      run_instr(c, op, fn, rd, fl, fw, -1);
      for (int p = 0; p < n_ph; p++) begin
        tests_run++;
        if (obs_q[p] !== exp_q[p]) begin
          tests_failed++;
          $display("FAIL random[%0d] c=%b op=%b fn=%b rd=%0d %s got %h expected %h", i, c, op,
                   fn, rd, ph_name(ph_q[p]), obs_q[p], exp_q[p]);
        end
      end
    end
    // The last instruction must have ended: the next cycle is a FETCH.
    @(negedge clk);
    tests_run++;
    if (w_obs !== model_out(P_FETCH, m_ce, bus.Op, bus.Rd)) begin
      tests_failed++;
      $display("FAIL final_fetch got %h expected %h", w_obs,
               model_out(P_FETCH, m_ce, bus.Op, bus.Rd));
    end
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_subs_branch();
    test_ldr_str();
    test_pc_dest();
    test_reset_midinstr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
